// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard/forwarding scoreboard of the pipelined
// MIPS core.
//   - Stage indices of the records tracked after D: E=1, M=2, W=3.
//   - HI/LO destination address.
//   - Default widths, depth and mult/div busy lengths.
//   - max_int(): sizes the mult/div counter so it fits either load value.
package hazard_scoreboard_pkg;

    localparam int STAGE_E = 1;
    localparam int STAGE_M = 2;
    localparam int STAGE_W = 3;

    localparam int DEF_DEPTH       = 3;
    localparam int DEF_AW          = 6;
    localparam int DEF_TW          = 3;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Top bit of the address space selects HI/LO rather than a GPR.
    localparam logic [DEF_AW-1:0] HILO_ADDR = 6'b100000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// hs_match: nearest-match search for one D-stage source operand.
// Ports:
//   rec_a  in  DEPTH*AW  destination of record k at bits [(k-1)*AW +: AW]
//   rec_t  in  DEPTH*TW  remaining Tnew of record k at bits [(k-1)*TW +: TW]
//   ause   in  AW        source address (0 = no source, never matches)
//   hit    out 1         some record writes this source
//   k      out FW        stage number (1..DEPTH) of the nearest match
//   t      out TW        remaining Tnew of the nearest match
module hs_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int TW    = DEF_TW,
    parameter int FW    = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH*AW-1:0] rec_a,
    input  logic [DEPTH*TW-1:0] rec_t,
    input  logic [AW-1:0]       ause,
    output logic                hit,
    output logic [FW-1:0]       k,
    output logic [TW-1:0]       t
);

    logic [DEPTH-1:0] eq;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_eq
            assign eq[gi] = (rec_a[gi*AW +: AW] == ause) && (ause != '0);
        end
    endgenerate

    // Scan from the farthest stage toward E so the lowest matching stage
    // is the last one assigned and therefore wins.
    always_comb begin
        hit = 1'b0;
        k   = '0;
        t   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eq[i]) begin
                hit = 1'b1;
                k   = FW'(i + 1);
                t   = rec_t[i*TW +: TW];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall and forward-select generation.
// Keeps one {destination, remaining Tnew} record per stage after D, ageing
// Tnew by one each cycle, and interlocks HI/LO users behind mult/div.
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   d_tnew, d_anew       Tnew and destination of the D instruction
//   d_tuse1/2, d_ause1/2 Tuse and address of each source (address 0 = none)
//   d_md_start, d_md_div D is mult/multu (div=0) or div/divu (div=1)
//   d_uses_hilo          D reads or writes HI/LO
//   stall                hold PC/D and send a bubble into E
//   fwd_sel1/2           0 = register file, k = result of stage k
//   md_busy              mult/div unit still working
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AW          = DEF_AW,
    parameter int TW          = DEF_TW,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int FW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [TW-1:0] d_tnew,
    input  logic [AW-1:0] d_anew,
    input  logic [TW-1:0] d_tuse1,
    input  logic [AW-1:0] d_ause1,
    input  logic [TW-1:0] d_tuse2,
    input  logic [AW-1:0] d_ause2,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_uses_hilo,
    output logic          stall,
    output logic [FW-1:0] fwd_sel1,
    output logic [FW-1:0] fwd_sel2,
    output logic          md_busy
);

    localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

    // Index gi holds stage gi+1 (E at index 0).
    logic [AW-1:0] a_reg  [DEPTH];
    logic [AW-1:0] a_next [DEPTH];
    logic [TW-1:0] t_reg  [DEPTH];
    logic [TW-1:0] t_next [DEPTH];
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    logic [DEPTH*AW-1:0] rec_a_flat;
    logic [DEPTH*TW-1:0] rec_t_flat;

    logic          hit1;
    logic          hit2;
    logic [FW-1:0] k1;
    logic [FW-1:0] k2;
    logic [TW-1:0] t1;
    logic [TW-1:0] t2;
    logic          haz1;
    logic          haz2;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - TW'(1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == STAGE_E - 1) begin : g_entry
                // A stalled D instruction is not issued: E gets a bubble.
                assign a_next[gi] = stall ? '0 : d_anew;
                assign t_next[gi] = stall ? '0 : sat_dec(d_tnew);
            end else begin : g_shift
                // Downstream stages keep moving even while D is held.
                assign a_next[gi] = a_reg[gi-1];
                assign t_next[gi] = sat_dec(t_reg[gi-1]);
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    a_reg[gi] <= '0;
                    t_reg[gi] <= '0;
                end else begin
                    a_reg[gi] <= a_next[gi];
                    t_reg[gi] <= t_next[gi];
                end
            end

            assign rec_a_flat[gi*AW +: AW] = a_reg[gi];
            assign rec_t_flat[gi*TW +: TW] = t_reg[gi];
        end
    endgenerate

    hs_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .TW    (TW),
        .FW    (FW)
    ) u_match1 (
        .rec_a (rec_a_flat),
        .rec_t (rec_t_flat),
        .ause  (d_ause1),
        .hit   (hit1),
        .k     (k1),
        .t     (t1)
    );

    hs_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .TW    (TW),
        .FW    (FW)
    ) u_match2 (
        .rec_a (rec_a_flat),
        .rec_t (rec_t_flat),
        .ause  (d_ause2),
        .hit   (hit2),
        .k     (k2),
        .t     (t2)
    );

    // Result not ready by the time the source needs it. Equality is fine:
    // the value arrives just in time through the downstream muxes.
    assign haz1 = hit1 && (t1 > d_tuse1);
    assign haz2 = hit2 && (t2 > d_tuse2);

    assign md_busy = (cnt_reg != '0);
    assign stall   = haz1 || haz2 || (d_uses_hilo && md_busy);

    // Only a finished result (t == 0) is forwarded from D's point of view.
    assign fwd_sel1 = (hit1 && (t1 == '0)) ? k1 : '0;
    assign fwd_sel2 = (hit2 && (t2 == '0)) ? k2 : '0;

    // A new mult/div issue reloads the counter even if one is running.
    always_comb begin
        cnt_next = cnt_reg;
        if (d_md_start && !stall) begin
            cnt_next = d_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule
